// File: rtl/muldiv_ctrl_pkg.sv
// Shared funct codes, FSM state encoding and op-select type for the HI/LO
// multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam int unsigned ITERATIONS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  // Encoding matches funct[1:0] of the accepted ops.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == FUNCT_MULT) || (func == FUNCT_MULTU) ||
           (func == FUNCT_DIV)  || (func == FUNCT_DIVU);
  endfunction

  function automatic op_t decode_op(input logic [5:0] func);
    return op_t'(func[1:0]);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and muldiv_ctrl.
interface muldiv_ctrl_if;
  logic        start;
  logic [5:0]  func;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, func, rs_val, rt_val, mf_req,
    input  busy, stall, done, div_zero, hi, lo
  );

  modport slave (
    input  start, func, rs_val, rt_val, mf_req,
    output busy, stall, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand, accumulator/remainder and HI/LO registers with the shared
// adder/subtractor; sequenced by load/step/fix from muldiv_ctrl.
module muldiv_datapath
  import muldiv_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        fix,
  input  op_t         op_sel,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  op_t         op;
  logic [31:0] opnd;     // multiplicand or divisor magnitude
  logic [31:0] acc_hi;   // product high half / partial remainder
  logic [31:0] acc_lo;   // multiplier / dividend, shifting into quotient
  logic        neg_q;
  logic        neg_r;

  logic        in_signed;
  logic        in_div;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        op_is_div;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;

  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  always_comb begin
    in_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    in_div    = (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
    a_abs     = in_signed ? abs32(a_in) : a_in;
    b_abs     = in_signed ? abs32(b_in) : b_in;
    op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  // One iteration of each algorithm; the divide compare is 33 bits wide but a
  // successful subtract always leaves a remainder that fits in 32.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_rem   = div_ge ? (div_shift[31:0] - opnd) : div_shift[31:0];
  end

  always_comb begin
    prod_fixed  = neg_q ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    quo_fixed   = neg_q ? (~acc_lo + 32'd1) : acc_lo;
    rem_fixed   = neg_r ? (~acc_hi + 32'd1) : acc_hi;
    div_by_zero = op_is_div && (opnd == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op     <= OP_MULT;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (load) begin
      op     <= op_sel;
      opnd   <= in_div ? b_abs : a_abs;
      acc_hi <= '0;
      acc_lo <= in_div ? a_abs : b_abs;
      neg_q  <= in_signed && (a_in[31] ^ b_in[31]);
      neg_r  <= in_signed && a_in[31];
    end else if (step) begin
      if (op_is_div) begin
        acc_hi <= div_rem;
        acc_lo <= {acc_lo[30:0], div_ge};
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
      end
    end else if (fix) begin
      if (!op_is_div) begin
        hi <= prod_fixed[63:32];
        lo <= prod_fixed[31:0];
      end else if (div_by_zero) begin
        // Quotient stays all-ones; the remainder already holds |dividend|.
        hi <= rem_fixed;
        lo <= '1;
      end else begin
        hi <= rem_fixed;
        lo <= quo_fixed;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: accepts MULT/MULTU/DIV/DIVU from EX,
// runs 32 iterations in muldiv_datapath and stalls dependent instructions.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  state_t     state;
  logic [4:0] count;
  logic       busy_q;
  logic       done_q;
  logic       div_zero_q;

  logic       accept;
  logic       dp_load;
  logic       dp_step;
  logic       dp_fix;
  logic       dp_div_by_zero;

  always_comb begin
    accept  = (state == ST_IDLE) && bus.start && is_muldiv(bus.func);
    dp_load = accept;
    dp_step = (state == ST_RUN);
    dp_fix  = (state == ST_FIX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_RUN;
            count  <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          count <= count + 5'd1;
          if (count == 5'(ITERATIONS - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state      <= ST_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          div_zero_q <= dp_div_by_zero;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  muldiv_datapath u_datapath (
    .clock       (clock),
    .reset       (reset),
    .load        (dp_load),
    .step        (dp_step),
    .fix         (dp_fix),
    .op_sel      (decode_op(bus.func)),
    .a_in        (bus.rs_val),
    .b_in        (bus.rt_val),
    .div_by_zero (dp_div_by_zero),
    .hi          (bus.hi),
    .lo          (bus.lo)
  );

  // Independent instructions flow while busy; only HI/LO readers and a second
  // mul/div are held.
  assign bus.stall    = busy_q && (bus.mf_req || (bus.start && is_muldiv(bus.func)));
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clock, reset.
REQ-002 Ports SHALL be, clock and reset first (name  direction  width  meaning):
  clock  in  1  rising-edge clock.
  reset  in  1  asynchronous active-low reset.
  start  in  1  EX-stage R-format instruction valid, opcode R_FORMAT.
  func  in  6  funct field of the EX-stage instruction.
  rs_val  in  32  operand A (multiplicand / dividend).
  rt_val  in  32  operand B (multiplier / divisor).
  mf_req  in  1  EX-stage instruction is MFHI or MFLO.
  busy  out  1  operation in progress.
  stall  out  1  freeze IF/ID/EX and bubble MEM.
  done  out  1  one-cycle pulse when HI/LO are written.
  div_zero  out  1  one-cycle pulse with done when the divisor was zero.
  hi  out  32  HI register.
  lo  out  32  LO register.

Function
REQ-003 Accepted ops: func MULT 011000, MULTU 011001, DIV 011010, DIVU 011011; any other func with start=1 SHALL be ignored.
REQ-004 FSM states: IDLE, RUN, FIX. IDLE->RUN on an accepted start; RUN->FIX when the 5-bit counter reaches 31; FIX->IDLE unconditionally.
REQ-005 On the accepting edge E, the block SHALL latch the op, the operand magnitudes (two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU), the result sign bits, and clear the counter.
REQ-006 RUN SHALL perform exactly one iteration per cycle: shift-add multiply (64-bit accumulator) or restoring divide (one quotient bit, 33-bit partial remainder subtract); 32 iterations, edges E+1..E+32.
REQ-007 At edge E+33 (FIX), the block SHALL apply sign fixup and write HI/LO, then return to IDLE; hi/lo SHALL reflect the result in the cycle after edge E+33.
REQ-008 Multiply: {hi,lo} SHALL equal the 64-bit product, negated when the MULT operand signs differ.
REQ-009 Divide: lo SHALL equal the quotient and hi the remainder; for DIV the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
REQ-010 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (no trap).
REQ-011 Divisor zero: lo SHALL be 0xFFFFFFFF, hi SHALL be the dividend (before sign fixup for DIV), and div_zero SHALL pulse with done.
REQ-012 busy SHALL be 1 in every state other than IDLE (33 cycles per op); done SHALL be registered, high for exactly the one cycle after the FIX edge.
REQ-013 stall SHALL be busy & (mf_req | (start & func is an accepted op)), combinational; independent instructions SHALL proceed while busy.
REQ-014 start while busy SHALL NOT alter state, operands or counter.
REQ-015 start in the cycle done=1 SHALL be accepted normally (back-to-back ops, 34-cycle spacing).
REQ-016 hi/lo SHALL change only at the FIX edge or on reset.

Reset
REQ-017 reset=0 SHALL immediately force IDLE, counter=0, hi=lo=0, busy=done=div_zero=stall-contributing state=0, and abort any in-flight op.
REQ-018 After reset deasserts, the first accepted start SHALL behave exactly as REQ-005..REQ-012.

Structure
REQ-019 The funct codes MULT/MULTU/DIV/DIVU/MFHI (010000)/MFLO (010010) and the state encodings SHALL live in the shared constants.h.
REQ-020 The block SHALL be split into the FSM/counter in muldiv_ctrl and one sub-module, muldiv_datapath (operand, accumulator and remainder registers, adder/subtractor), driven by state and op-select lines.

Verification
REQ-021 MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 busy cycles, hi=0xFFFFFFFE, lo=0x00000001, done pulse once.
REQ-022 MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-023 DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, div_zero=1 coincident with done; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-024 mf_req=1 at cycle E+5 -> stall=1 until busy falls; an unrelated ADD during busy -> stall=0; a second MULT during busy -> stall=1 and operands unchanged.
REQ-025 reset=0 asserted at cycle E+10 -> busy=0 and hi=lo=0 immediately; a new DIVU 9/4 afterwards -> lo=2, hi=1.
REQ-026 MULTU 3*5 issued in the done cycle of a prior op -> accepted; hi=0, lo=15 after 34 more cycles.
